// File: rtl/cla_serial_pkg.sv
// rtl/cla_serial_pkg.sv - shared types and constants for the byte-serial adder
package cla_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/cla_8bit.sv
// rtl/cla_8bit.sv - 8-bit carry-lookahead adder stage (combinational)
module cla_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum of products over lower generate/propagate terms.
    always_comb begin
        logic cc;
        logic pp;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            cc = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & cin);
        end
    end

    assign sum  = p ^ c[7:0];
    assign cout = c[8];

endmodule

// File: rtl/cla_serial_adder.sv
// rtl/cla_serial_adder.sv - byte-serial wide adder over cla_8bit; CLA_SERIAL_OVF_EN adds ovf
module cla_serial_adder
    import cla_serial_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
`ifdef CLA_SERIAL_OVF_EN
    output logic                  ovf,
`endif
    output logic                  cout
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last_byte;
    logic [7:0]       a_i;
    logic [7:0]       b_i;
    logic [8:0]       s1;
    logic [8:0]       s2;

    assign a_i       = a_q[BYTE_W*idx_q +: BYTE_W];
    assign b_i       = b_q[BYTE_W*idx_q +: BYTE_W];
    assign last_byte = (idx_q == LAST_IDX);
    assign accept    = in_valid && in_ready;

    cla_8bit u_add0 (
        .a    (a_i),
        .b    (b_i),
        .cin  (1'b0),
        .sum  (s1[7:0]),
        .cout (s1[8])
    );

    // Adding the registered carry as a second operand keeps the byte chain strictly sequential.
    cla_8bit u_add1 (
        .a    (s1[7:0]),
        .b    ({7'b0, carry_q}),
        .cin  (1'b0),
        .sum  (s2[7:0]),
        .cout (s2[8])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last_byte) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            BUSY: begin
                sum_d[BYTE_W*idx_q +: BYTE_W] = s2[7:0];
                carry_d = s1[8] | s2[8];
                idx_d   = idx_q + IDX_W'(1);
                if (last_byte) begin
                    cout_d = carry_d;
                    ovf_d  = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
                end
            end
            default: ;
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef CLA_SERIAL_OVF_EN
    assign ovf  = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_serial_adder.sv
// tb/tb_cla_serial_adder.sv - directed self-checking bench for cla_serial_adder (NBYTES=4)
module tb_cla_serial_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef CLA_SERIAL_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    cla_serial_adder #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef CLA_SERIAL_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 64'(in_ready), 64'd1);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'hCAFE_F00D;
        cin      = 1'b1;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd4);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, input logic [31:0] es, input logic ec, input logic eo);
        start_op(av, bv, cv);
        wait_out(tag);
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef CLA_SERIAL_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) check({tag, "_ovf_x"}, 64'(eo), 64'd0);
`endif
        finish_op(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        run_op("basic", 32'd3, 32'd5, 1'b0, 32'd8, 1'b0, 1'b0);
        run_op("ripple_all", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        run_op("ripple_mid", 32'h00FF_FF00, 32'h0000_0100, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
        run_op("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1);

        // Backpressure: result must hold while out_ready stays low.
        start_op(32'h1234_5678, 32'h1111_1111, 1'b1);
        wait_out("bp");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_sum", 64'(sum), 64'h2345_678A);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        finish_op("bp");

        // Reset in the second BUSY cycle discards the operation.
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_valid", 64'(out_valid), 64'd0);
        end
        run_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        // in_valid together with out_ready in DONE: only the output handshake completes.
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_out("overlap");
        check("overlap_sum", 64'(sum), 64'h0000_0100);
        a         = 32'h0000_0010;
        b         = 32'h0000_0020;
        cin       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("overlap_ov_drop", 64'(out_valid), 64'd0);
        check("overlap_idle", 64'(in_ready), 64'd1);
        start_op(32'h0000_0010, 32'h0000_0020, 1'b1);
        wait_out("overlap2");
        check("overlap2_sum", 64'(sum), 64'h0000_0031);
        finish_op("overlap2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
